dma_cmd_sequencer: RTL and testbench

- Front-end controller that accepts 25-bit software command words, buffers them in a small FIFO, and sequences each one.
- Bit 24 = 0: the command goes to the processor for execution.
- Bit 24 = 1: the block requests the bus from the processor through the HOLD/HLDA handshake, launches the DMA engine with the decoded source, destination and length fields, then releases the bus.
- Sits between the instruction source and the processor/DMA pair, and replaces ad-hoc per-cycle decoding with an ordered, handshaked scheduler.

---
 rtl/dma_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dma_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_sequencer.sv
// dma_cmd_sequencer: buffers 25-bit command words in a small FIFO and issues
// them strictly in order, either to the processor (bit 24 = 0) or to the DMA
// engine via a HOLD/HLDA bus handshake (bit 24 = 1).
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   cmd_valid/cmd_data      command offer; cmd_ready when FIFO has room
//   cpu_enable/cpu_instr    one-cycle issue pulse and held command word
//   cpu_done                processor finished current command
//   HOLD/HLDA               bus request / grant
//   dma_start/src/dst/len   one-cycle launch pulse and held DMA fields
//   dma_done                DMA transfer complete
//   busy, fifo_count        activity and FIFO occupancy
//   timeout_err/err_clr     sticky HLDA-timeout flag and its clear
module dma_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned HLDA_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [24:0]      cmd_data,
    output logic             cmd_ready,
    output logic             cpu_enable,
    output logic [24:0]      cpu_instr,
    input  logic             cpu_done,
    output logic             HOLD,
    input  logic             HLDA,
    output logic             dma_start,
    output logic [7:0]       dma_src,
    output logic [7:0]       dma_dst,
    output logic [7:0]       dma_len,
    input  logic             dma_done,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int unsigned CMD_W = 25;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TMR_W = $clog2(HLDA_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CPU_RUN  = 3'd1;
    localparam logic [2:0] ST_HOLD_REQ = 3'd2;
    localparam logic [2:0] ST_DMA_RUN  = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    // FIFO storage and control
    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CMD_W-1:0] head;
    logic             push;
    logic             pop;

    // FSM state and next-state/output values
    logic [2:0]       state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [23:0]      cmd_reg, cmd_reg_nxt;
    logic             hold_nxt;
    logic             cpu_enable_nxt;
    logic [24:0]      cpu_instr_nxt;
    logic             dma_start_nxt;
    logic [7:0]       dma_src_nxt, dma_dst_nxt, dma_len_nxt;
    logic             timeout_err_nxt;

    // A full FIFO refuses pushes even if the head pops on the same edge.
    assign cmd_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE) || (count != '0);

    // FIFO pointers, occupancy and storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            cmd_reg     <= '0;
            HOLD        <= 1'b0;
            cpu_enable  <= 1'b0;
            cpu_instr   <= '0;
            dma_start   <= 1'b0;
            dma_src     <= '0;
            dma_dst     <= '0;
            dma_len     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            cmd_reg     <= cmd_reg_nxt;
            HOLD        <= hold_nxt;
            cpu_enable  <= cpu_enable_nxt;
            cpu_instr   <= cpu_instr_nxt;
            dma_start   <= dma_start_nxt;
            dma_src     <= dma_src_nxt;
            dma_dst     <= dma_dst_nxt;
            dma_len     <= dma_len_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        cmd_reg_nxt     = cmd_reg;
        hold_nxt        = HOLD;
        cpu_enable_nxt  = 1'b0;
        cpu_instr_nxt   = cpu_instr;
        dma_start_nxt   = 1'b0;
        dma_src_nxt     = dma_src;
        dma_dst_nxt     = dma_dst;
        dma_len_nxt     = dma_len;
        timeout_err_nxt = timeout_err;
        pop             = 1'b0;

        if (err_clr) begin
            timeout_err_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (!head[24]) begin
                        cpu_instr_nxt  = head;
                        cpu_enable_nxt = 1'b1;
                        state_nxt      = ST_CPU_RUN;
                    end else if (head[7:0] != 8'd0) begin
                        cmd_reg_nxt = head[23:0];
                        hold_nxt    = 1'b1;
                        timer_nxt   = '0;
                        state_nxt   = ST_HOLD_REQ;
                    end
                    // zero-length DMA commands are popped and dropped
                end
            end
            ST_CPU_RUN: begin
                if (cpu_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD_REQ: begin
                // a grant on the final timer cycle still wins
                if (HLDA) begin
                    dma_src_nxt   = cmd_reg[23:16];
                    dma_dst_nxt   = cmd_reg[15:8];
                    dma_len_nxt   = cmd_reg[7:0];
                    dma_start_nxt = 1'b1;
                    state_nxt     = ST_DMA_RUN;
                end else if (timer == TMR_W'(HLDA_TIMEOUT - 1)) begin
                    hold_nxt        = 1'b0;
                    timeout_err_nxt = 1'b1;
                    state_nxt       = ST_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ST_DMA_RUN: begin
                if (dma_done) begin
                    hold_nxt  = 1'b0;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                hold_nxt = 1'b0;
                if (!HLDA) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                hold_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer: inputs change and outputs are sampled
// on the falling clock edge, half a period away from the active edge.
module tb_dma_cmd_sequencer;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [24:0] cmd_data;
    logic        cmd_ready;
    logic        cpu_enable;
    logic [24:0] cpu_instr;
    logic        cpu_done;
    logic        HOLD;
    logic        HLDA;
    logic        dma_start;
    logic [7:0]  dma_src;
    logic [7:0]  dma_dst;
    logic [7:0]  dma_len;
    logic        dma_done;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        timeout_err;
    logic        err_clr;

    int          n_checks;
    int          n_pass;
    int          n_cpu;
    int          n_dma;
    int          n_acc;
    logic [24:0] instr_q[$];
    logic [24:0] cmds[5];
    int          hold_cycles;

    dma_cmd_sequencer #(
        .FIFO_DEPTH  (4),
        .CNT_W       (3),
        .HLDA_TIMEOUT(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .cpu_enable (cpu_enable),
        .cpu_instr  (cpu_instr),
        .cpu_done   (cpu_done),
        .HOLD       (HOLD),
        .HLDA       (HLDA),
        .dma_start  (dma_start),
        .dma_src    (dma_src),
        .dma_dst    (dma_dst),
        .dma_len    (dma_len),
        .dma_done   (dma_done),
        .busy       (busy),
        .fifo_count (fifo_count),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: an offered command that is accepted is withdrawn afterwards,
    // and issue pulses are tallied.
    task automatic tick();
        logic acc;
        acc = cmd_valid && cmd_ready;
        @(negedge clock);
        if (acc) begin
            cmd_valid = 1'b0;
            n_acc++;
        end
        if (cpu_enable) begin
            n_cpu++;
            instr_q.push_back(cpu_instr);
        end
        if (dma_start) begin
            n_dma++;
        end
    endtask

    task automatic clear_tallies();
        n_cpu = 0;
        n_dma = 0;
        n_acc = 0;
        instr_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cpu_done  = 1'b0;
        HLDA      = 1'b0;
        dma_done  = 1'b0;
        err_clr   = 1'b0;
        clear_tallies();
        tick();
        tick();

        // reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_hold", 32'(HOLD), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_cpu_en", 32'(cpu_enable), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        // CPU command
        clear_tallies();
        cmd_valid = 1'b1;
        cmd_data  = 25'h0010204;
        tick();
        check("cpu_count_after_push", 32'(fifo_count), 32'd1);
        check("cpu_en_not_yet", 32'(cpu_enable), 32'd0);
        tick();
        check("cpu_en_pulse", 32'(cpu_enable), 32'd1);
        check("cpu_instr", 32'(cpu_instr), 32'h0010204);
        check("cpu_hold_low", 32'(HOLD), 32'd0);
        check("cpu_count_pop", 32'(fifo_count), 32'd0);
        tick();
        check("cpu_en_single", 32'(cpu_enable), 32'd0);
        tick();
        check("cpu_busy_wait", 32'(busy), 32'd1);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("cpu_busy_fall", 32'(busy), 32'd0);
        check("cpu_instr_held", 32'(cpu_instr), 32'h0010204);

        // DMA command with grant two cycles after HOLD
        clear_tallies();
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, 8'h00, 8'h0A, 8'h04};
        tick();
        tick();
        check("dma_hold_rise", 32'(HOLD), 32'd1);
        tick();
        check("dma_hold_wait", 32'(HOLD), 32'd1);
        check("dma_no_start_yet", 32'(dma_start), 32'd0);
        HLDA = 1'b1;
        tick();
        check("dma_start_pulse", 32'(dma_start), 32'd1);
        check("dma_src", 32'(dma_src), 32'h00);
        check("dma_dst", 32'(dma_dst), 32'h0A);
        check("dma_len", 32'(dma_len), 32'h04);
        tick();
        check("dma_start_single", 32'(dma_start), 32'd0);
        check("dma_hold_run", 32'(HOLD), 32'd1);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check("dma_hold_fall", 32'(HOLD), 32'd0);
        check("dma_busy_release", 32'(busy), 32'd1);
        tick();
        check("dma_release_waits_hlda", 32'(busy), 32'd1);
        HLDA = 1'b0;
        tick();
        check("dma_idle", 32'(busy), 32'd0);
        check("dma_fields_held", 32'({dma_src, dma_dst, dma_len}), 32'h000A04);

        // FIFO fill behind a stalled DMA, then in-order issue
        clear_tallies();
        cmds[0] = 25'h0111111;
        cmds[1] = 25'h0222222;
        cmds[2] = 25'h0333333;
        cmds[3] = 25'h0444444;
        cmds[4] = 25'h0555555;
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, 8'h11, 8'h22, 8'h33};
        tick();
        tick();
        HLDA = 1'b1;
        tick();
        check("fill_dma_start", 32'(dma_start), 32'd1);
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = cmds[i];
            tick();
        end
        check("fill_accepted", 32'(n_acc), 32'd4);
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_ready_low", 32'(cmd_ready), 32'd0);
        check("fill_hold_stalled", 32'(HOLD), 32'd1);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        HLDA     = 1'b0;
        cpu_done = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        cpu_done = 1'b0;
        check("fill_fifth_accepted", 32'(n_acc), 32'd5);
        check("fill_cpu_issues", 32'(n_cpu), 32'd5);
        for (int i = 0; i < instr_q.size() && i < 5; i++) begin
            check($sformatf("fill_order_%0d", i), 32'(instr_q[i]), 32'(cmds[i]));
        end
        check("fill_drained", 32'(fifo_count), 32'd0);
        check("fill_idle", 32'(busy), 32'd0);

        // HLDA timeout, following command still proceeds
        clear_tallies();
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, 8'hAA, 8'hBB, 8'h01};
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 25'h0ABCDEF;
        tick();
        hold_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            if (HOLD) begin
                hold_cycles++;
            end
            tick();
        end
        check("tmo_hold_cycles", 32'(hold_cycles), 32'd16);
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        check("tmo_no_dma_start", 32'(n_dma), 32'd0);
        check("tmo_next_issued", 32'(n_cpu), 32'd1);
        check("tmo_next_instr", 32'(cpu_instr), 32'h0ABCDEF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(timeout_err), 32'd0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;

        // zero-length DMA is dropped, next command issues next cycle
        clear_tallies();
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, 8'h55, 8'h66, 8'h00};
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 25'h0123456;
        tick();
        check("zlen_no_hold", 32'(HOLD), 32'd0);
        check("zlen_count", 32'(fifo_count), 32'd1);
        check("zlen_no_cpu_yet", 32'(cpu_enable), 32'd0);
        tick();
        check("zlen_next_issue", 32'(cpu_enable), 32'd1);
        check("zlen_next_instr", 32'(cpu_instr), 32'h0123456);
        check("zlen_no_dma", 32'(n_dma), 32'd0);
        check("zlen_hold_still_low", 32'(HOLD), 32'd0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;

        // async reset during DMA_RUN with two commands queued
        clear_tallies();
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, 8'h01, 8'h02, 8'h03};
        tick();
        tick();
        HLDA = 1'b1;
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 25'h0000001;
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 25'h0000002;
        tick();
        check("rst_run_count", 32'(fifo_count), 32'd2);
        check("rst_run_hold", 32'(HOLD), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_hold", 32'(HOLD), 32'd0);
        check("rst_async_count", 32'(fifo_count), 32'd0);
        tick();
        HLDA = 1'b0;
        tick();
        reset = 1'b0;
        clear_tallies();
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("rst_post_no_cpu", 32'(n_cpu), 32'd0);
        check("rst_post_no_dma", 32'(n_dma), 32'd0);
        check("rst_post_idle", 32'(busy), 32'd0);
        check("rst_post_ready", 32'(cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
